booth_multiplier_seq_32: RTL and testbench
==========================================

# booth_multiplier_seq_32

- Sequential signed Booth multiplier for the Mini-SRC ALU.
- It is the multiply counterpart of the array divider: a 32 x 32 two's-complement product split into HI/LO words.
- It iterates one Booth digit per clock under a start/done handshake.
- The ALU control sequencer starts it on MUL and stalls until done, then writes HI/LO.

## Interface
- WIDTH, 32, operand width in bits; must be even and >= 4.
- in_clk  input  1  rising-edge clock
- in_reset  input  1  asynchronous, active-high reset
- in_start  input  1  request; sampled only in IDLE
- in_multiplicand  input  WIDTH  signed operand M
- in_multiplier  input  WIDTH  signed operand Q
- out_busy  output  1  high while in RUN or DONE
- out_done  output  1  one-cycle pulse; result valid
- out_hi  output  WIDTH  upper word of the 2*WIDTH-bit signed product
- out_lo  output  WIDTH  lower word of the 2*WIDTH-bit signed product

## Operation
- Reset values: state=IDLE, out_busy=0, out_done=0, out_hi=0, out_lo=0, iteration counter=0.
- IDLE:
  - in_start=1 latches M and Q, clears the accumulator A (WIDTH+2 bits) and the implied bit q[-1]=0, and loads counter=N.
  - The next state is RUN.
- RUN, each cycle:
  - Booth-recode the low bits of Q together with q[-1] and add the selected multiple of M to A.
  - Shift {A,Q,q[-1]} right arithmetically by the digit width and decrement the counter.
  - When the counter reaches 1, go to DONE.
- Radix-4 digit recode on {q1,q0,q-1}:
  - 000 or 111 -> 0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- Radix-2 digit recode on {q0,q-1}:
  - 00 or 11 -> 0
  - 01 -> +M
  - 10 -> -M
- Arithmetic: M is sign-extended to WIDTH+2 bits before forming 2M or a negation. All adds are modulo 2^(WIDTH+2), with no overflow flag. The product of any two WIDTH-bit signed values is exact in 2*WIDTH bits.
- DONE, one cycle:
  - out_hi = A[WIDTH-1:0] and out_lo = Q register.
  - out_done=1; the next state is IDLE.
- out_hi and out_lo change only on entry to DONE. They hold until the next DONE or reset.
- in_start is ignored in RUN and DONE; there is no queuing.
- Operand inputs are not sampled after the accepting edge, so they may change freely during RUN.
- in_reset asserted at any time forces the reset values immediately and aborts the operation; no done pulse is produced for it.

## Timing
- N = WIDTH/2 iterations with radix-4 and N = WIDTH with radix-2.
- The start-accept edge is T0.
- out_busy goes high after T0 and stays high for N+1 cycles.
- out_done is high for exactly the cycle after the Nth RUN edge: N+1 cycles after T0, i.e. 17 (radix-4) or 33 (radix-2) for WIDTH=32.
- out_busy falls together with out_done on the edge leaving DONE.
- The earliest next start is the first IDLE cycle after DONE, which gives back-to-back throughput of one product per N+2 cycles.
- in_start held high continuously restarts immediately on each IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BOOTH_RADIX4_EN defined:
  - Radix-4 recoding, N=WIDTH/2.
  - Adder input mux selects 0, ±M or ±2M; shift is 2 per cycle.
- BOOTH_RADIX4_EN undefined:
  - Radix-2 Booth, N=WIDTH.
  - Mux selects 0 or ±M; shift is 1 per cycle.
- Results are identical in both builds; only latency differs.

## Test plan
- M=7, Q=5, start -> done pulse exactly N+1 cycles after accept; hi=0x00000000, lo=0x00000023; busy high throughout.
- M=-12 (0xFFFFFFF4), Q=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFAC.
- M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000.
- M=Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
  - Then M=0x80000000, Q=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- Start 3*4; pulse in_start again with other operands during RUN and drive new operand values -> second start is ignored, result hi=0, lo=0x0000000C, and only one done pulse occurs.
- Assert in_reset mid-RUN after a prior result exists -> outputs are zero immediately, busy=0, and no done pulse appears.
  - A new start of -1 x -1 then yields hi=0, lo=1.

Source files
------------

// File: rtl/booth_multiplier_seq_32.sv
// Sequential signed Booth multiplier, one digit per clock, HI/LO result.
// Define BOOTH_RADIX4_EN for radix-4 recoding; radix-2 otherwise.
module booth_multiplier_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_multiplicand,
  input  logic [WIDTH-1:0] in_multiplier,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int AW = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
  localparam int N  = WIDTH / 2;
  localparam int SH = 2;
`else
  localparam int N  = WIDTH;
  localparam int SH = 1;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_nx;

  logic [AW-1:0]    m_q;
  logic [AW-1:0]    a_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [AW-1:0]       mult;
  logic [AW-1:0]       sum;
  logic [AW+WIDTH:0]   shifted;
  logic [AW-1:0]       a_nx;
  logic [WIDTH-1:0]    q_nx;
  logic                qm1_nx;
  logic                last;

  always_comb begin
    mult = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001,
      3'b010:  mult = m_q;
      3'b011:  mult = m_q << 1;
      3'b100:  mult = -(m_q << 1);
      3'b101,
      3'b110:  mult = -m_q;
      default: mult = '0;
    endcase
`else
    case ({q_q[0], qm1_q})
      2'b01:   mult = m_q;
      2'b10:   mult = -m_q;
      default: mult = '0;
    endcase
`endif
  end

  // {A,Q,q[-1]} is shifted as one signed word so A's sign fills in.
  always_comb begin
    sum     = a_q + mult;
    shifted = $unsigned($signed({sum, q_q, qm1_q}) >>> SH);
    a_nx    = shifted[AW+WIDTH -: AW];
    q_nx    = shifted[WIDTH:1];
    qm1_nx  = shifted[0];
    last    = (cnt_q == CW'(1));
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (in_start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      busy_q  <= (state_nx != IDLE);
      done_q  <= (state_nx == DONE);
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_start) begin
            m_q   <= {{2{in_multiplicand[WIDTH-1]}},
                      in_multiplicand};
            a_q   <= '0;
            q_q   <= in_multiplier;
            qm1_q <= 1'b0;
            cnt_q <= CW'(N);
          end
        end
        RUN: begin
          a_q   <= a_nx;
          q_q   <= q_nx;
          qm1_q <= qm1_nx;
          cnt_q <= cnt_q - CW'(1);
          // Publish on the DONE entry edge so HI/LO never show partials.
          if (last) begin
            hi_q <= a_nx[WIDTH-1:0];
            lo_q <= q_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_busy = busy_q;
  assign out_done = done_q;
  assign out_hi   = hi_q;
  assign out_lo   = lo_q;

endmodule

// File: tb/tb_booth_multiplier_seq_32.sv
// Self-checking bench for booth_multiplier_seq_32.
// Reference products come from plain 64-bit signed multiplication.
module tb_booth_multiplier_seq_32;

`ifdef BOOTH_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mc = '0;
  logic [31:0] mp = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  booth_multiplier_seq_32 dut (
    .in_clk          (clk),
    .in_reset        (rst),
    .in_start        (start),
    .in_multiplicand (mc),
    .in_multiplier   (mp),
    .out_busy        (busy),
    .out_done        (done),
    .out_hi          (hi),
    .out_lo          (lo)
  );

  function automatic logic [63:0] ref_mul(
    input logic [31:0] m,
    input logic [31:0] q
  );
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p;
  endfunction

  task automatic mul(
    input logic [31:0] m,
    input logic [31:0] q,
    input int          pulse_at,
    input string       name
  );
    logic [63:0] p;
    logic [31:0] eh, el, gh, gl;
    int done_at, pulses, busy_err, hold_err;
    p = ref_mul(m, q);
    eh = p[63:32];
    el = p[31:0];
    gh = '0;
    gl = '0;
    done_at = 0;
    pulses = 0;
    busy_err = 0;
    hold_err = 0;
    @(negedge clk);
    start = 1'b1;
    mc = m;
    mp = q;
    for (int cyc = 1; cyc <= N + 5; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_at);
      mc = $urandom;
      mp = $urandom;
      if (done === 1'b1) begin
        pulses++;
        if (done_at == 0) begin
          done_at = cyc;
          gh = hi;
          gl = lo;
        end
      end
      if (busy !== (cyc <= N + 1)) busy_err++;
      if (cyc <= N && (hi !== last_hi || lo !== last_lo))
        hold_err++;
    end
    start = 1'b0;
    checks++;
    if (done_at != N + 1) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d",
               name, done_at, N + 1);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d exp 1", name, pulses);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("FAIL %s busy_profile got %0d bad cycles exp 0",
               name, busy_err);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL %s hold_before_done got %0d bad cycles exp 0",
               name, hold_err);
    end
    checks++;
    if (gh !== eh) begin
      errors++;
      $display("FAIL %s hi got %h exp %h", name, gh, eh);
    end
    checks++;
    if (gl !== el) begin
      errors++;
      $display("FAIL %s lo got %h exp %h", name, gl, el);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s hold_after_done got %h_%h exp %h_%h",
               name, hi, lo, eh, el);
    end
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset busy_done got %b exp 00", {busy, done});
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset hilo got %h_%h exp 0_0", hi, lo);
    end
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    mul(32'd7, 32'd5, 0, "7x5");
    mul(32'hFFFFFFF4, 32'd7, 0, "m12x7");
    mul(32'h80000000, 32'h80000000, 0, "minxmin");
    mul(32'h7FFFFFFF, 32'h7FFFFFFF, 0, "maxxmax");
    mul(32'h80000000, 32'h7FFFFFFF, 0, "minxmax");
  endtask

  task automatic test_ignore_start();
    mul(32'd3, 32'd4, 3, "ignore_start");
  endtask

  task automatic test_random();
    logic [31:0] m, q;
    for (int i = 0; i < 12; i++) begin
      m = $urandom;
      q = $urandom;
      if (i == 0) m = 32'hFFFFFFFF;
      if (i == 1) q = 32'h80000000;
      mul(m, q, (i % 3 == 0) ? 2 + i : 0, "random");
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    mul(32'd9, 32'hFFFFFFFD, 0, "prior");
    @(negedge clk);
    start = 1'b1;
    mc = 32'd123;
    mp = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL abort outputs got %b_%h_%h exp 00_0_0",
               {busy, done}, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    pulses = 0;
    for (int c = 0; c < N + 5; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort no_done got %0d active cycles exp 0",
               pulses);
    end
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "m1xm1");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ms [3];
    logic [31:0] qs [3];
    logic [63:0] p;
    int idx, prev;
    ms[0] = $urandom;
    qs[0] = $urandom;
    ms[1] = 32'hFFFFFFF4;
    qs[1] = $urandom;
    ms[2] = $urandom;
    qs[2] = 32'h7FFFFFFF;
    idx = 0;
    prev = 0;
    @(negedge clk);
    start = 1'b1;
    mc = ms[0];
    mp = qs[0];
    for (int cyc = 1; cyc <= 3 * (N + 2) + 5; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 && idx < 3) begin
        p = ref_mul(ms[idx], qs[idx]);
        checks++;
        if (hi !== p[63:32] || lo !== p[31:0]) begin
          errors++;
          $display("FAIL b2b_%0d result got %h_%h exp %h",
                   idx, hi, lo, p);
        end
        checks++;
        if (cyc - prev != ((idx == 0) ? N + 1 : N + 2)) begin
          errors++;
          $display("FAIL b2b_%0d interval got %0d exp %0d", idx,
                   cyc - prev, (idx == 0) ? N + 1 : N + 2);
        end
        prev = cyc;
        last_hi = p[63:32];
        last_lo = p[31:0];
        idx++;
        if (idx < 3) begin
          mc = ms[idx];
          mp = qs[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL b2b count got %0d exp 3", idx);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
